dibu_datapath_mc: RTL and testbench
===================================

Name: dibu_datapath_mc

Overview:
Parametrised multi-cycle successor of the single-issue datapath, with data width and code depth as parameters. Adds an internal fetch/decode/execute FSM and conditional/unconditional jumps. Also adds HALT, a retired-instruction counter and a guarded code-load port. It sits at the top of the core, drives the code memory, register bank, ALU and flags register, and replaces the external opcode-driven control unit.

Parameters:
DATA_W, 8, register/ALU/immediate width; legal range 8..32.
ADDR_W, 9, code address width; code depth = 2^ADDR_W words; legal range 4..11.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
run  input  1  enable execution
code_w_en  input  1  code memory write strobe
code_addr_in  input  ADDR_W  code write address
code_in  input  16  code write data
debug  output  DATA_W  last value written to the register bank
pc_out  output  ADDR_W  current program counter
busy  output  1  high in FETCH/DECODE/EXEC
halted  output  1  high in HALT state
retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, ir=0, all 8 registers=0, flags=0, debug=0, retired=0, busy=0, halted=0. Code memory contents are not reset. Deassertion takes effect at the next clk edge.
- Instruction fields (fixed 16 bit):
  - op=ir[15:11], rd=ir[10:8], ra=ir[5:3], rb=ir[2:0]
  - imm=ir[7:0], zero-extended to DATA_W
  - jump target=ir[ADDR_W-1:0]
- Opcodes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 NOT ra, 00110 SHL ra by 1, 00111 SHR ra by 1 (logical). Each does rd<=result and updates flags.
  - 01000 MOVI: rd<=imm; flags unchanged.
  - 01001 MOVF: rd<=zero-extended flags.
  - 01010 CMP: computes ra-rb and updates flags only.
  - 10000 JMP; 10001 JZ; 10010 JC; 10011 JN: pc<=target when the condition holds.
  - 11111 HALT.
  - All other opcodes are NOP and still count as retired.
- Flags, 4 bits {V,N,C,Z} at [3:0]:
  - Z: result==0. N: result[DATA_W-1].
  - C: carry-out for ADD; borrow (a<b unsigned) for SUB/CMP; shifted-out bit for SHL/SHR; 0 otherwise.
  - V: signed overflow for ADD/SUB/CMP; 0 otherwise.
- FSM:
  - IDLE: if run=1 -> FETCH.
  - FETCH: code memory addr=pc (synchronous read) -> DECODE.
  - DECODE: ir<=mem data; pc<=pc+1 (wraps 2^ADDR_W-1 -> 0) -> EXEC.
  - EXEC: register/flags writeback, jump pc load, retired+1.
    - If op==HALT -> HALT.
    - Else if run=1 -> FETCH.
    - Else -> IDLE.
  - HALT: stays in HALT until reset.
  - Cost is exactly 3 cycles per instruction; a taken jump overrides the pc+1 from DECODE.
- run=0 mid-instruction: the current instruction completes through EXEC, then the FSM enters IDLE. State is preserved; resuming continues at pc.
- Code load:
  - code_w_en is honoured only in IDLE or HALT; memory addr=code_addr_in while writing.
  - In FETCH/DECODE/EXEC the write is ignored and memory is not modified.
  - A write and run=1 in the same IDLE cycle: the write occurs, the FSM still moves to FETCH, and the fetch sees the new word if the address matches.
- Register file: 8 entries. Read is asynchronous. One write per cycle, EXEC only. debug updates on the same edge as the register write.
- retired wraps modulo 2^CNT_W.
- Arithmetic is modulo 2^DATA_W.

Test Plan:
- Load MOVI r1,0x05; MOVI r2,0x03; ADD r3,r1,r2; HALT. Pulse run. -> debug=0x08 after cycle 9, halted=1 after cycle 12, retired=4, pc_out=4.
- With r1=0xFF and r2=0x01, execute ADD then MOVF r4. -> r4 result 0x03 (Z=1, C=1), visible on debug.
- Load CMP r1,r1; JZ 0x10; with HALT at 0x10 and MOVI r5,0xAA at 0x02. -> jump taken, r5 never written, pc_out=0x11 at halt.
- Run a long program and drop run during DECODE. -> instruction completes, busy falls, state is IDLE. Raise run again -> the next instruction executes with no skip.
- Assert code_w_en during EXEC targeting an address holding 0x4155. -> content unchanged on read-back. Repeat in IDLE -> content written.
- Assert rst_n=0 asynchronously mid-EXEC. -> all outputs 0 immediately. Code memory is retained, and re-running replays the program from pc=0.

Source files
------------

// File: rtl/dibu_datapath_mc.sv
// ---------------------------------------------------------------------------
// dibu_datapath_mc
//
// Multi-cycle datapath core with its own fetch/decode/execute sequencer.
// Every instruction costs exactly three clocks (FETCH, DECODE, EXEC). The
// core owns a 16-bit wide code memory, an 8-entry register bank, the ALU and
// a {V,N,C,Z} flags register. Conditional and unconditional jumps, HALT and a
// retired-instruction counter are supported. The code memory can be loaded
// through a write port that is only honoured while the core is parked in
// IDLE or HALT.
//
// Parameters
//   DATA_W : register / ALU / immediate width (8..32)
//   ADDR_W : code address width, code depth is 2**ADDR_W words (4..11)
//   CNT_W  : width of the retired-instruction counter
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   run          : enable execution
//   code_w_en    : code memory write strobe
//   code_addr_in : code memory write address
//   code_in      : code memory write data (one 16-bit instruction)
//   debug        : last value written to the register bank
//   pc_out       : current program counter
//   busy         : high while in FETCH, DECODE or EXEC
//   halted       : high once a HALT instruction has executed
//   retired      : number of completed instructions (wraps)
//
// Instruction format (16 bit)
//   [15:11] op  [10:8] rd  [7:0] imm  [5:3] ra  [2:0] rb
//   jump target = ir[ADDR_W-1:0]
// ---------------------------------------------------------------------------
module dibu_datapath_mc #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              code_w_en,
   input  logic [ADDR_W-1:0] code_addr_in,
   input  logic [15:0]       code_in,
   output logic [DATA_W-1:0] debug,
   output logic [ADDR_W-1:0] pc_out,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  retired
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int MSB   = DATA_W - 1;

   // Opcode encodings
   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_NOT  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_MOVI = 5'b01000;
   localparam logic [4:0] OP_MOVF = 5'b01001;
   localparam logic [4:0] OP_CMP  = 5'b01010;
   localparam logic [4:0] OP_JMP  = 5'b10000;
   localparam logic [4:0] OP_JZ   = 5'b10001;
   localparam logic [4:0] OP_JC   = 5'b10010;
   localparam logic [4:0] OP_JN   = 5'b10011;
   localparam logic [4:0] OP_HALT = 5'b11111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_HALT
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   pc;
   logic [15:0]         ir;
   logic [DATA_W-1:0]   regs [8];
   logic [3:0]          flags;

   // Code memory and its synchronous read register
   logic [15:0]         code_mem [DEPTH];
   logic [15:0]         mem_q;
   logic                load_ok;
   logic [ADDR_W-1:0]   mem_addr;

   // Decoded fields
   logic [4:0]          op;
   logic [2:0]          rd;
   logic [2:0]          ra;
   logic [2:0]          rb;
   logic [7:0]          imm;
   logic [ADDR_W-1:0]   target;

   // ALU signals
   logic [DATA_W-1:0]   opa;
   logic [DATA_W-1:0]   opb;
   logic [DATA_W:0]     sum;
   logic [DATA_W:0]     diff;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_c;
   logic                alu_v;
   logic [3:0]          alu_flags;

   // Writeback control
   logic                reg_we;
   logic                flags_we;
   logic [DATA_W-1:0]   wdata;
   logic                take_jump;

   assign pc_out = pc;

   assign op     = ir[15:11];
   assign rd     = ir[10:8];
   assign ra     = ir[5:3];
   assign rb     = ir[2:0];
   assign imm    = ir[7:0];
   assign target = ir[ADDR_W-1:0];

   // Loads are only accepted while the sequencer is parked, so a running
   // program can never be modified underneath itself. While a load is
   // accepted the single memory port is steered to the load address.
   assign load_ok  = code_w_en && ((state == ST_IDLE) || (state == ST_HALT));
   assign mem_addr = load_ok ? code_addr_in : pc;

   // Code memory: not reset, synchronous read. The word read during FETCH
   // lands in mem_q and is captured into ir during DECODE. A load in the
   // IDLE cycle that starts a run is therefore visible to the first fetch.
   always_ff @(posedge clk) begin
      if (load_ok) begin
         code_mem[mem_addr] <= code_in;
      end
      mem_q <= code_mem[mem_addr];
   end

   // ALU: operands come straight from the asynchronous register read. Carry
   // for subtraction/compare is the borrow, i.e. the extra top bit of the
   // widened difference. Overflow is the usual sign-mismatch test.
   always_comb begin
      opa     = regs[ra];
      opb     = regs[rb];
      sum     = {1'b0, opa} + {1'b0, opb};
      diff    = {1'b0, opa} - {1'b0, opb};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum[DATA_W-1:0];
            alu_c   = sum[DATA_W];
            alu_v   = (opa[MSB] == opb[MSB]) && (alu_res[MSB] != opa[MSB]);
         end
         OP_SUB, OP_CMP: begin
            alu_res = diff[DATA_W-1:0];
            alu_c   = diff[DATA_W];
            alu_v   = (opa[MSB] != opb[MSB]) && (alu_res[MSB] != opa[MSB]);
         end
         OP_AND: alu_res = opa & opb;
         OP_OR:  alu_res = opa | opb;
         OP_XOR: alu_res = opa ^ opb;
         OP_NOT: alu_res = ~opa;
         OP_SHL: begin
            alu_res = {opa[DATA_W-2:0], 1'b0};
            alu_c   = opa[MSB];
         end
         OP_SHR: begin
            alu_res = {1'b0, opa[DATA_W-1:1]};
            alu_c   = opa[0];
         end
         default: begin
            alu_res = '0;
         end
      endcase
      alu_flags = {alu_v, alu_res[MSB], alu_c, (alu_res == '0)};
   end

   // Writeback selection. The eight ALU opcodes occupy 00000..00111, so the
   // top two opcode bits being zero identifies them. MOVI and MOVF write the
   // bank but leave flags alone; CMP updates flags only.
   always_comb begin
      reg_we   = 1'b0;
      flags_we = 1'b0;
      wdata    = alu_res;
      if (op[4:3] == 2'b00) begin
         reg_we   = 1'b1;
         flags_we = 1'b1;
      end else if (op == OP_MOVI) begin
         reg_we     = 1'b1;
         wdata      = '0;
         wdata[7:0] = imm;
      end else if (op == OP_MOVF) begin
         reg_we     = 1'b1;
         wdata      = '0;
         wdata[3:0] = flags;
      end else if (op == OP_CMP) begin
         flags_we = 1'b1;
      end
   end

   // Jump conditions look at the flags left behind by earlier instructions.
   always_comb begin
      case (op)
         OP_JMP:  take_jump = 1'b1;
         OP_JZ:   take_jump = flags[0];
         OP_JC:   take_jump = flags[1];
         OP_JN:   take_jump = flags[2];
         default: take_jump = 1'b0;
      endcase
   end

   // Sequencer and architectural state. busy and halted are registered and
   // set alongside every state transition so they always match the state
   // being entered. In EXEC a taken jump overrides the pc+1 done in DECODE.
   // Dropping run only takes effect at the end of EXEC, so an instruction in
   // flight always completes and pc is left pointing at the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         pc      <= '0;
         ir      <= '0;
         flags   <= '0;
         debug   <= '0;
         retired <= '0;
         busy    <= 1'b0;
         halted  <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            regs[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (run) begin
                  state <= ST_FETCH;
                  busy  <= 1'b1;
               end
            end
            ST_FETCH: begin
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               ir    <= mem_q;
               pc    <= pc + 1'b1;
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (reg_we) begin
                  regs[rd] <= wdata;
                  debug    <= wdata;
               end
               if (flags_we) begin
                  flags <= alu_flags;
               end
               if (take_jump) begin
                  pc <= target;
               end
               retired <= retired + 1'b1;
               if (op == OP_HALT) begin
                  state  <= ST_HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else if (run) begin
                  state <= ST_FETCH;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state  <= ST_IDLE;
               busy   <= 1'b0;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dibu_datapath_mc.sv
// ---------------------------------------------------------------------------
// tb_dibu_datapath_mc
//
// Self-checking bench for dibu_datapath_mc (default parameters). A table of
// ALU vectors with hand-derived results is run as one program, followed by
// hand-written sequences for halting, jumps, stopping/resuming, guarded code
// loads and asynchronous reset, and finally a randomized program checked
// instruction by instruction against an instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_dibu_datapath_mc;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 9;
   localparam int CNT_W  = 16;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int FULL   = 1 << DATA_W;
   localparam int HALF   = 1 << (DATA_W - 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              run;
   logic              code_w_en;
   logic [ADDR_W-1:0] code_addr_in;
   logic [15:0]       code_in;
   logic [DATA_W-1:0] debug;
   logic [ADDR_W-1:0] pc_out;
   logic              busy;
   logic              halted;
   logic [CNT_W-1:0]  retired;

   int total = 0;
   int bad   = 0;

   dibu_datapath_mc #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .code_w_en   (code_w_en),
      .code_addr_in(code_addr_in),
      .code_in     (code_in),
      .debug       (debug),
      .pc_out      (pc_out),
      .busy        (busy),
      .halted      (halted),
      .retired     (retired)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Safety net so the run always terminates
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // ------------------------------------------------------------------
   // Instruction-level reference model
   // ------------------------------------------------------------------
   logic [15:0] m_mem [DEPTH];
   int          m_regs [8];
   int          m_flags;
   int          m_pc;
   int          m_retired;
   int          m_debug;
   int          m_halted;

   function automatic int sx(input int x);
      return (x >= HALF) ? x - FULL : x;
   endfunction

   function automatic int ovf(input int s);
      return ((s > HALF - 1) || (s < -HALF)) ? 1 : 0;
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      m_flags   = 0;
      m_pc      = 0;
      m_retired = 0;
      m_debug   = 0;
      m_halted  = 0;
   endfunction

   // Executes the instruction at m_pc using plain arithmetic on the fields
   function automatic void modelStep();
      int w, op, rd, ra, rb, imm, a, b, res, c, v;
      bit wr, fl;
      w   = int'(m_mem[m_pc]);
      op  = w / 2048;
      rd  = (w / 256) % 8;
      ra  = (w / 8) % 8;
      rb  = w % 8;
      imm = w % 256;
      a   = m_regs[ra];
      b   = m_regs[rb];
      res = 0; c = 0; v = 0; wr = 0; fl = 0;
      m_pc      = (m_pc + 1) % DEPTH;
      m_retired = (m_retired + 1) % (1 << CNT_W);
      case (op)
         0: begin res = (a + b) % FULL; c = (a + b >= FULL) ? 1 : 0;
                  v = ovf(sx(a) + sx(b)); wr = 1; fl = 1; end
         1: begin res = (a - b + FULL) % FULL; c = (a < b) ? 1 : 0;
                  v = ovf(sx(a) - sx(b)); wr = 1; fl = 1; end
         2: begin res = a & b; wr = 1; fl = 1; end
         3: begin res = a | b; wr = 1; fl = 1; end
         4: begin res = a ^ b; wr = 1; fl = 1; end
         5: begin res = FULL - 1 - a; wr = 1; fl = 1; end
         6: begin res = (a * 2) % FULL; c = (a >= HALF) ? 1 : 0; wr = 1; fl = 1; end
         7: begin res = a / 2; c = a % 2; wr = 1; fl = 1; end
         8: begin m_regs[rd] = imm; m_debug = imm; end
         9: begin m_regs[rd] = m_flags; m_debug = m_flags; end
         10: begin res = (a - b + FULL) % FULL; c = (a < b) ? 1 : 0;
                   v = ovf(sx(a) - sx(b)); fl = 1; end
         16: m_pc = w % DEPTH;
         17: if (m_flags % 2 == 1) m_pc = w % DEPTH;
         18: if ((m_flags / 2) % 2 == 1) m_pc = w % DEPTH;
         19: if ((m_flags / 4) % 2 == 1) m_pc = w % DEPTH;
         31: m_halted = 1;
         default: ;
      endcase
      if (wr) begin
         m_regs[rd] = res;
         m_debug    = res;
      end
      if (fl) begin
         m_flags = v * 8 + ((res >= HALF) ? 4 : 0) + c * 2 + ((res == 0) ? 1 : 0);
      end
   endfunction

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // One code-load cycle; accept says whether the core should take it
   task automatic applyStimulus(input int addr, input logic [15:0] data, input bit accept);
      code_w_en    = 1'b1;
      code_addr_in = ADDR_W'(addr);
      code_in      = data;
      @(posedge clk); #1;
      code_w_en    = 1'b0;
      if (accept) m_mem[addr] = data;
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      run       = 1'b0;
      code_w_en = 1'b0;
      #2;
      modelReset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Let one instruction run to completion and compare with the model
   task automatic checkInstr(input string name);
      logic exp_busy;
      repeat (3) @(posedge clk);
      #1;
      modelStep();
      exp_busy = run && (m_halted == 0);
      checkOutput({name, " debug"},   32'(debug),   32'(m_debug));
      checkOutput({name, " pc"},      32'(pc_out),  32'(m_pc));
      checkOutput({name, " retired"}, 32'(retired), 32'(m_retired));
      checkOutput({name, " halted"},  32'(halted),  32'(m_halted));
      checkOutput({name, " busy"},    32'(busy),    32'(exp_busy));
   endtask

   function automatic logic [15:0] enc(input int op, input int rd, input int ra, input int rb);
      return 16'(op * 2048 + rd * 256 + ra * 8 + rb);
   endfunction

   function automatic logic [15:0] movi(input int rd, input int imm);
      return 16'(8 * 2048 + rd * 256 + imm);
   endfunction

   // ------------------------------------------------------------------
   // ALU vector table: op on r1/r2 into r3, then MOVF r4
   // ------------------------------------------------------------------
   typedef struct {
      int op;
      int a;
      int b;
      int res;
      int flags;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   int op_list [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 16, 17, 18, 19, 11, 21, 30};

   initial begin
      vecs[0]  = '{0,  8'h05, 8'h03, 8'h08, 4'h0};
      vecs[1]  = '{0,  8'hFF, 8'h01, 8'h00, 4'h3};
      vecs[2]  = '{0,  8'h7F, 8'h01, 8'h80, 4'hC};
      vecs[3]  = '{1,  8'h03, 8'h05, 8'hFE, 4'h6};
      vecs[4]  = '{1,  8'h80, 8'h01, 8'h7F, 4'h8};
      vecs[5]  = '{2,  8'hF0, 8'h3C, 8'h30, 4'h0};
      vecs[6]  = '{3,  8'h0F, 8'hF0, 8'hFF, 4'h4};
      vecs[7]  = '{4,  8'hAA, 8'hAA, 8'h00, 4'h1};
      vecs[8]  = '{5,  8'h0F, 8'h33, 8'hF0, 4'h4};
      vecs[9]  = '{6,  8'h81, 8'h00, 8'h02, 4'h2};
      vecs[10] = '{7,  8'h01, 8'h00, 8'h00, 4'h3};
      vecs[11] = '{7,  8'h80, 8'h00, 8'h40, 4'h0};
      // CMP writes no register, so debug still shows the second MOVI
      vecs[12] = '{10, 8'h05, 8'h05, 8'h05, 4'h1};

      rst_n        = 1'b0;
      run          = 1'b0;
      code_w_en    = 1'b0;
      code_addr_in = '0;
      code_in      = '0;
      modelReset();

      // Reset state
      #12;
      checkOutput("reset debug",   32'(debug),   32'h0);
      checkOutput("reset pc",      32'(pc_out),  32'h0);
      checkOutput("reset retired", 32'(retired), 32'h0);
      checkOutput("reset busy",    32'(busy),    32'h0);
      checkOutput("reset halted",  32'(halted),  32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // ---------------- table-driven ALU vectors ----------------
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(4 * i + 0, movi(1, vecs[i].a), 1'b1);
         applyStimulus(4 * i + 1, movi(2, vecs[i].b), 1'b1);
         applyStimulus(4 * i + 2, enc(vecs[i].op, 3, 1, 2), 1'b1);
         applyStimulus(4 * i + 3, enc(9, 4, 0, 0), 1'b1);
      end
      applyStimulus(4 * NVEC, 16'hF800, 1'b1);
      run = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < NVEC; i++) begin
         for (int j = 0; j < 4; j++) begin
            int exp_val;
            repeat (3) @(posedge clk);
            #1;
            modelStep();
            case (j)
               0:       exp_val = vecs[i].a;
               1:       exp_val = vecs[i].b;
               2:       exp_val = vecs[i].res;
               default: exp_val = vecs[i].flags;
            endcase
            checkOutput($sformatf("vec%0d step%0d debug", i, j), 32'(debug), 32'(exp_val));
         end
      end
      checkInstr("vec halt");
      repeat (5) @(posedge clk);
      #1;
      checkOutput("halt sticky halted", 32'(halted), 32'h1);
      checkOutput("halt sticky pc",     32'(pc_out), 32'(4 * NVEC + 1));

      // ---------------- basic program to HALT ----------------
      doReset();
      applyStimulus(0, 16'h4105, 1'b1);
      applyStimulus(1, 16'h4203, 1'b1);
      applyStimulus(2, 16'h030A, 1'b1);
      applyStimulus(3, 16'hF800, 1'b1);
      run = 1'b1;
      @(posedge clk); #1;
      checkInstr("prog movi1");
      checkInstr("prog movi2");
      checkInstr("prog add");
      checkOutput("prog add value", 32'(debug), 32'h08);
      checkInstr("prog halt");
      checkOutput("prog halted",  32'(halted),  32'h1);
      checkOutput("prog retired", 32'(retired), 32'h4);
      checkOutput("prog pc",      32'(pc_out),  32'h4);

      // ---------------- taken conditional jump ----------------
      doReset();
      applyStimulus(0,     16'h5009, 1'b1);
      applyStimulus(1,     16'h8810, 1'b1);
      applyStimulus(2,     16'h45AA, 1'b1);
      applyStimulus(16'h10, 16'hF800, 1'b1);
      run = 1'b1;
      @(posedge clk); #1;
      checkInstr("jz cmp");
      checkInstr("jz jump");
      checkOutput("jz target pc", 32'(pc_out), 32'h10);
      checkInstr("jz halt");
      checkOutput("jz halt pc",   32'(pc_out), 32'h11);
      checkOutput("jz no r5 write", 32'(debug), 32'h0);

      // ---------------- stop during DECODE and resume ----------------
      doReset();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(i, (i == 7) ? 16'h4155 : movi(i % 8, 16 + i), 1'b1);
      end
      run = 1'b1;
      @(posedge clk); #1;
      checkInstr("stop i0");
      checkInstr("stop i1");
      checkInstr("stop i2");
      @(posedge clk); #1;          // now in DECODE of i3
      run = 1'b0;
      @(posedge clk); #1;          // EXEC of i3
      checkOutput("stop exec busy", 32'(busy), 32'h1);
      @(posedge clk); #1;          // back in IDLE
      modelStep();
      checkOutput("stop i3 debug",   32'(debug),   32'h13);
      checkOutput("stop idle busy",  32'(busy),    32'h0);
      checkOutput("stop retired",    32'(retired), 32'(m_retired));
      checkOutput("stop pc",         32'(pc_out),  32'(m_pc));
      repeat (4) @(posedge clk);
      #1;
      checkOutput("stop hold retired", 32'(retired), 32'h4);
      checkOutput("stop hold pc",      32'(pc_out),  32'h4);
      run = 1'b1;
      @(posedge clk); #1;
      checkInstr("resume i4");
      checkOutput("resume no skip", 32'(debug), 32'h14);

      // ---------------- guarded code load ----------------
      code_w_en    = 1'b1;                 // held across FETCH/DECODE/EXEC
      code_addr_in = ADDR_W'(7);
      code_in      = 16'h4177;
      checkInstr("guard i5");
      code_w_en    = 1'b0;
      checkInstr("guard i6");
      checkInstr("guard i7");
      checkOutput("guard busy write ignored", 32'(debug), 32'h55);
      run = 1'b0;
      checkInstr("guard i8");
      run = 1'b1;                          // load and start in the same cycle
      applyStimulus(9, 16'h4177, 1'b1);
      checkInstr("guard i9");
      checkOutput("guard idle write taken", 32'(debug), 32'h77);

      // ---------------- asynchronous reset mid-EXEC ----------------
      @(posedge clk); #1;                  // DECODE
      @(posedge clk); #1;                  // EXEC
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("areset debug",   32'(debug),   32'h0);
      checkOutput("areset pc",      32'(pc_out),  32'h0);
      checkOutput("areset retired", 32'(retired), 32'h0);
      checkOutput("areset busy",    32'(busy),    32'h0);
      checkOutput("areset halted",  32'(halted),  32'h0);
      run = 1'b0;
      modelReset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      run   = 1'b1;
      @(posedge clk); #1;
      checkInstr("replay i0");
      checkOutput("replay first value", 32'(debug), 32'h10);
      checkInstr("replay i1");

      // ---------------- randomized program ----------------
      doReset();
      for (int i = 0; i < DEPTH; i++) begin
         int op;
         op = op_list[$urandom_range(0, 17)];
         applyStimulus(i, 16'(op * 2048 + $urandom_range(0, 2047)), 1'b1);
      end
      run = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 7) == 0) run = 1'b0;
         checkInstr($sformatf("rand%0d", i));
         if (!run) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            checkOutput("rand idle busy", 32'(busy), 32'h0);
            run = 1'b1;
            @(posedge clk); #1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
